cc_unit: RTL and testbench

- Execute-stage condition-code register and condition evaluator for the Y86-64 pipeline.
- Consumes the 64-bit ALU's result, zero and overflow outputs, and latches ZF/SF/OF on OPq instructions.
- Evaluates the jXX/cmovXX condition (e_cnd) from the latched flags.
- Gates flag updates on pipeline bubbles, stalls and downstream exceptions.

---
 rtl/y86_pkg.sv | 26 ++
 rtl/cond_eval.sv | 34 +++
 rtl/cc_unit.sv | 132 +++++++++++++
 tb/tb_cc_unit.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: icodes, condition ifuns and ALU op codes.
package y86_pkg;

  // Instruction codes relevant to condition-code handling
  localparam logic [3:0] IC_CMOV = 4'h2;
  localparam logic [3:0] IC_OPQ  = 4'h6;
  localparam logic [3:0] IC_JXX  = 4'h7;

  // Condition function codes for jXX / cmovXX
  localparam logic [3:0] C_ALWAYS = 4'h0;
  localparam logic [3:0] C_LE     = 4'h1;
  localparam logic [3:0] C_L      = 4'h2;
  localparam logic [3:0] C_E      = 4'h3;
  localparam logic [3:0] C_NE     = 4'h4;
  localparam logic [3:0] C_GE     = 4'h5;
  localparam logic [3:0] C_G      = 4'h6;

  // ALU operation encodings carried in the low ifun bits of OPq
  typedef enum logic [1:0] {
    ALU_ADD = 2'd0,
    ALU_SUB = 2'd1,
    ALU_AND = 2'd2,
    ALU_XOR = 2'd3
  } alu_op_e;

endpackage

// File: rtl/cond_eval.sv
// Pure combinational jXX/cmovXX condition evaluator.
// Maps (ZF, SF, OF, ifun) to a taken bit and an illegal-ifun flag.
// Shared with the branch-predict checker, so it has no icode knowledge.
module cond_eval
  import y86_pkg::*;
(
  input  logic       zf,
  input  logic       sf,
  input  logic       of,
  input  logic [3:0] ifun,
  output logic       cnd,
  output logic       err
);

  logic lt;
  assign lt = sf ^ of;

  // Decode the condition; reserved ifuns give not-taken plus err
  always_comb begin
    cnd = 1'b0;
    err = 1'b0;
    case (ifun)
      C_ALWAYS: cnd = 1'b1;
      C_LE:     cnd = lt | zf;
      C_L:      cnd = lt;
      C_E:      cnd = zf;
      C_NE:     cnd = ~zf;
      C_GE:     cnd = ~lt;
      C_G:      cnd = ~lt & ~zf;
      default:  err = 1'b1;
    endcase
  end

endmodule

// File: rtl/cc_unit.sv
// Execute-stage condition-code register and condition evaluator.
// Latches ZF/SF/OF from the ALU on committed OPq instructions and
// evaluates the jXX/cmov condition from the latched (not bypassed) flags.
// Optional build macro CC_STATS_EN adds saturating condition-evaluation
// and taken counters.
module cc_unit
  import y86_pkg::*;
#(
  parameter int unsigned W          = 64,
  parameter logic [3:0]  ICODE_OPQ  = IC_OPQ,
  parameter logic [3:0]  ICODE_JXX  = IC_JXX,
  parameter logic [3:0]  ICODE_CMOV = IC_CMOV
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         e_valid,
  input  logic         e_stall,
  input  logic [3:0]   e_icode,
  input  logic [3:0]   e_ifun,
  input  logic [W-1:0] alu_res,
  input  logic         alu_zero,
  input  logic         alu_overflow,
  input  logic         m_exc,
  input  logic         w_exc,
  output logic         cc_zf,
  output logic         cc_sf,
  output logic         cc_of,
  output logic         e_cnd,
  output logic         cnd_err,
  output logic         cc_upd
`ifdef CC_STATS_EN
  ,
  output logic [31:0]  cnd_eval_cnt,
  output logic [31:0]  cnd_taken_cnt
`endif
);

  logic zf_q, sf_q, of_q, upd_q;
  logic zf_d, sf_d, of_d, upd_d;
  logic set_cc;
  logic is_cond_op;
  logic cnd_raw, err_raw;

  // Only the sign bit of the result matters here
  logic alu_res_unused;
  assign alu_res_unused = ^alu_res[W-2:0];

  // Flags may only change for a real, advancing OPq that no younger
  // exception will squash
  assign set_cc = e_valid & ~e_stall & (e_icode == ICODE_OPQ) & ~m_exc & ~w_exc;

  assign is_cond_op = (e_icode == ICODE_JXX) | (e_icode == ICODE_CMOV);

  cond_eval u_cond_eval (
    .zf   (zf_q),
    .sf   (sf_q),
    .of   (of_q),
    .ifun (e_ifun),
    .cnd  (cnd_raw),
    .err  (err_raw)
  );

  assign e_cnd   = cnd_raw;
  assign cnd_err = err_raw & is_cond_op;

  // Next-state for the flag register and the one-cycle update pulse
  always_comb begin
    zf_d  = zf_q;
    sf_d  = sf_q;
    of_d  = of_q;
    upd_d = 1'b0;
    if (set_cc) begin
      zf_d  = alu_zero;
      sf_d  = alu_res[W-1];
      of_d  = alu_overflow;
      upd_d = 1'b1;
    end
  end

  // Flag register; reset leaves ZF set so an 'e' condition is true
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zf_q  <= 1'b1;
      sf_q  <= 1'b0;
      of_q  <= 1'b0;
      upd_q <= 1'b0;
    end else begin
      zf_q  <= zf_d;
      sf_q  <= sf_d;
      of_q  <= of_d;
      upd_q <= upd_d;
    end
  end

  assign cc_zf  = zf_q;
  assign cc_sf  = sf_q;
  assign cc_of  = of_q;
  assign cc_upd = upd_q;

`ifdef CC_STATS_EN
  logic [31:0] eval_q, eval_d;
  logic [31:0] taken_q, taken_d;
  logic        count_eval;

  assign count_eval = e_valid & ~e_stall & is_cond_op;

  // Saturating counters of evaluated and taken conditions
  always_comb begin
    eval_d  = eval_q;
    taken_d = taken_q;
    if (count_eval) begin
      if (eval_q != 32'hFFFF_FFFF) eval_d = eval_q + 32'd1;
      if (cnd_raw && (taken_q != 32'hFFFF_FFFF)) taken_d = taken_q + 32'd1;
    end
  end

  // Counter registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      eval_q  <= 32'd0;
      taken_q <= 32'd0;
    end else begin
      eval_q  <= eval_d;
      taken_q <= taken_d;
    end
  end

  assign cnd_eval_cnt  = eval_q;
  assign cnd_taken_cnt = taken_q;
`endif

endmodule

// File: tb/tb_cc_unit.sv
// Self-checking bench for cc_unit: directed steps followed by random
// traffic, all checked against a flag-level reference model.
module tb_cc_unit;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        e_valid = 1'b0;
  logic        e_stall = 1'b0;
  logic [3:0]  e_icode = 4'h1;
  logic [3:0]  e_ifun = 4'h0;
  logic [63:0] alu_res = 64'd0;
  logic        alu_zero = 1'b0;
  logic        alu_overflow = 1'b0;
  logic        m_exc = 1'b0;
  logic        w_exc = 1'b0;
  logic        cc_zf, cc_sf, cc_of, e_cnd, cnd_err, cc_upd;
`ifdef CC_STATS_EN
  logic [31:0] cnd_eval_cnt, cnd_taken_cnt;
`endif

  int n_pass = 0;
  int n_total = 0;

  // Reference model state
  bit          m_zf = 1'b1, m_sf = 1'b0, m_of = 1'b0, m_upd = 1'b0;
  int unsigned m_eval = 0, m_taken = 0;

  always #5 clk = ~clk;

  cc_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .e_valid      (e_valid),
    .e_stall      (e_stall),
    .e_icode      (e_icode),
    .e_ifun       (e_ifun),
    .alu_res      (alu_res),
    .alu_zero     (alu_zero),
    .alu_overflow (alu_overflow),
    .m_exc        (m_exc),
    .w_exc        (w_exc),
    .cc_zf        (cc_zf),
    .cc_sf        (cc_sf),
    .cc_of        (cc_of),
    .e_cnd        (e_cnd),
    .cnd_err      (cnd_err),
    .cc_upd       (cc_upd)
`ifdef CC_STATS_EN
    ,
    .cnd_eval_cnt (cnd_eval_cnt),
    .cnd_taken_cnt(cnd_taken_cnt)
`endif
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Condition truth from the architectural meaning: "less" is SF^OF
  function automatic bit ref_cnd(input bit zf, input bit sf, input bit of, input int fn);
    bit less;
    less = (sf != of);
    case (fn)
      0: return 1'b1;
      1: return less || zf;
      2: return less;
      3: return zf;
      4: return !zf;
      5: return !less;
      6: return !less && !zf;
      default: return 1'b0;
    endcase
  endfunction

  // One clock of stimulus: check combinational outputs, clock, check state
  task automatic step(input bit v, input bit st, input logic [3:0] ic, input logic [3:0] fn,
                      input logic [63:0] res, input bit z, input bit ov,
                      input bit me, input bit we, input string tag);
    bit exp_cnd, exp_err, is_br, wr;
    e_valid = v; e_stall = st; e_icode = ic; e_ifun = fn;
    alu_res = res; alu_zero = z; alu_overflow = ov; m_exc = me; w_exc = we;
    #1;
    is_br   = (ic == 4'h7) || (ic == 4'h2);
    exp_cnd = ref_cnd(m_zf, m_sf, m_of, int'(fn));
    exp_err = is_br && (fn > 4'd6);
    chk({tag, ".e_cnd"}, 64'(e_cnd), 64'(exp_cnd));
    chk({tag, ".cnd_err"}, 64'(cnd_err), 64'(exp_err));
    wr = v && !st && (ic == 4'h6) && !me && !we;
    @(posedge clk);
    #1;
    if (v && !st && is_br) begin
      if (m_eval != 32'hFFFF_FFFF) m_eval++;
      if (exp_cnd && m_taken != 32'hFFFF_FFFF) m_taken++;
    end
    if (wr) begin
      m_zf = z; m_sf = res[63]; m_of = ov;
    end
    m_upd = wr;
    chk({tag, ".zf"}, 64'(cc_zf), 64'(m_zf));
    chk({tag, ".sf"}, 64'(cc_sf), 64'(m_sf));
    chk({tag, ".of"}, 64'(cc_of), 64'(m_of));
    chk({tag, ".upd"}, 64'(cc_upd), 64'(m_upd));
`ifdef CC_STATS_EN
    chk({tag, ".eval_cnt"}, 64'(cnd_eval_cnt), 64'(m_eval));
    chk({tag, ".taken_cnt"}, 64'(cnd_taken_cnt), 64'(m_taken));
`endif
    $display("step %-10s v=%0b st=%0b ic=%0h fn=%0h res=%016h z=%0b ov=%0b mx=%0b wx=%0b -> zf=%0b sf=%0b of=%0b upd=%0b",
             tag, v, st, ic, fn, res, z, ov, me, we, cc_zf, cc_sf, cc_of, cc_upd);
  endtask

  task automatic idle(input string tag);
    step(1'b0, 1'b0, 4'h1, 4'h0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, tag);
  endtask

  initial begin
    // Power-up reset
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("por.zf", 64'(cc_zf), 64'd1);
    chk("por.upd", 64'(cc_upd), 64'd0);

    // Disturb the flags, then reset asynchronously mid-cycle
    step(1'b1, 1'b0, 4'h6, 4'h1, 64'h8000_0000_0000_0001, 1'b0, 1'b1, 1'b0, 1'b0, "pre_rst");
    e_icode = 4'h7; e_ifun = 4'h3; e_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    m_zf = 1'b1; m_sf = 1'b0; m_of = 1'b0; m_upd = 1'b0; m_eval = 0; m_taken = 0;
    chk("rst.zf", 64'(cc_zf), 64'd1);
    chk("rst.sf", 64'(cc_sf), 64'd0);
    chk("rst.of", 64'(cc_of), 64'd0);
    chk("rst.upd", 64'(cc_upd), 64'd0);
    chk("rst.je", 64'(e_cnd), 64'd1);
`ifdef CC_STATS_EN
    chk("rst.eval_cnt", 64'(cnd_eval_cnt), 64'd0);
    chk("rst.taken_cnt", 64'(cnd_taken_cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Branch statistics from reset flags (ZF=1): e, ne, always, l, stalled
    step(1'b1, 1'b0, 4'h7, 4'h3, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "st_je");
    step(1'b1, 1'b0, 4'h7, 4'h4, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "st_jne");
    step(1'b1, 1'b0, 4'h7, 4'h0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "st_jmp");
    step(1'b1, 1'b0, 4'h7, 4'h2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "st_jl");
    step(1'b1, 1'b1, 4'h7, 4'h0, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "st_stall");
`ifdef CC_STATS_EN
    chk("stats.eval4", 64'(cnd_eval_cnt), 64'd4);
    chk("stats.taken2", 64'(cnd_taken_cnt), 64'd2);
`endif

    // SUB giving -5: SF=1, ZF=0, OF=0
    step(1'b1, 1'b0, 4'h6, 4'h1, 64'hFFFF_FFFF_FFFF_FFFB, 1'b0, 1'b0, 1'b0, 1'b0, "sub_neg");
    chk("sub.sf1", 64'(cc_sf), 64'd1);
    step(1'b1, 1'b0, 4'h7, 4'h2, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "jl");
    step(1'b1, 1'b0, 4'h7, 4'h6, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "jg");

    // ADD overflowing to 0x8000...: SF=1, OF=1
    step(1'b1, 1'b0, 4'h6, 4'h0, 64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0, 1'b0, "add_ovf");
    chk("add.of1", 64'(cc_of), 64'd1);
    step(1'b1, 1'b0, 4'h7, 4'h5, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "jge");
    step(1'b1, 1'b0, 4'h2, 4'h1, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "cmovle");

    // Suppressed updates: M exception, W exception, bubble, bubble+stall
    step(1'b1, 1'b0, 4'h6, 4'h2, 64'd0, 1'b1, 1'b0, 1'b1, 1'b0, "opq_mexc");
    step(1'b1, 1'b0, 4'h6, 4'h2, 64'd0, 1'b1, 1'b0, 1'b0, 1'b1, "opq_wexc");
    step(1'b0, 1'b0, 4'h6, 4'h2, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, "opq_bub");
    step(1'b0, 1'b1, 4'h6, 4'h2, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, "opq_bubst");
    chk("supp.zf0", 64'(cc_zf), 64'd0);

    // Stalled OPq: three held cycles, then one write on release
    for (int i = 0; i < 3; i++)
      step(1'b1, 1'b1, 4'h6, 4'h3, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, "opq_stall");
    step(1'b1, 1'b0, 4'h6, 4'h3, 64'd0, 1'b1, 1'b0, 1'b0, 1'b0, "opq_rel");
    chk("rel.zf1", 64'(cc_zf), 64'd1);
    idle("post_rel");

    // Reserved ifun: error only on jXX/cmov
    step(1'b1, 1'b0, 4'h7, 4'h9, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "j9");
    step(1'b1, 1'b0, 4'h6, 4'h9, 64'h7FFF_0000_0000_0000, 1'b0, 1'b0, 1'b0, 1'b0, "opq9");
    step(1'b1, 1'b0, 4'h2, 4'hF, 64'd0, 1'b0, 1'b0, 1'b0, 1'b0, "cmovF");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      logic [3:0]  ic, fn;
      logic [63:0] res;
      bit          v, st, z, ov, me, we;
      case ($urandom_range(0, 3))
        0: ic = 4'h6;
        1: ic = 4'h7;
        2: ic = 4'h2;
        default: ic = 4'($urandom_range(0, 15));
      endcase
      fn  = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(7, 15)) : 4'($urandom_range(0, 6));
      res = {$urandom, $urandom};
      z   = ($urandom_range(0, 3) == 0);
      if (z) res = 64'd0;
      v   = ($urandom_range(0, 7) != 0);
      st  = ($urandom_range(0, 4) == 0);
      ov  = ($urandom_range(0, 3) == 0);
      me  = ($urandom_range(0, 9) == 0);
      we  = ($urandom_range(0, 9) == 0);
      step(v, st, ic, fn, res, z, ov, me, we, "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  // Global watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "timeout");
  end

endmodule
